// File: rtl/sys_ctrl_rx_frame_decoder_pkg.sv
// Shared definitions for the system-controller RX frame decoder.
// Default command codes, register-file operand addresses and FSM states.
package sys_ctrl_rx_frame_decoder_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int ADDR_WIDTH_DEF     = 4;
    localparam int FUN_WIDTH_DEF      = 4;
    localparam int OPA_ADDR_DEF       = 0;
    localparam int OPB_ADDR_DEF       = 1;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    localparam logic [7:0] CMD_RF_WR_DEF   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD_DEF   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP_DEF  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP_DEF = 8'hDD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_OPA,
        S_OPB,
        S_FUN,
        S_WAIT_RSP
    } state_e;

    function automatic int timer_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/sys_ctrl_rx_frame_decoder_if.sv
// Bus between the RX byte source / RF / ALU side and the frame decoder.
// master drives bytes and responses, slave is the decoder.
interface sys_ctrl_rx_frame_decoder_if
    import sys_ctrl_rx_frame_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int FUN_WIDTH  = FUN_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  ALU_OUT_VALID;
    logic                  RD_DATA_VALID;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  EN;
    logic                  CLK_EN;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  BUSY;
    logic                  FRAME_ERR;
    logic                  TIMEOUT_ERR;

    modport master (
        output RX_P_DATA, RX_D_VLD, ALU_OUT_VALID, RD_DATA_VALID,
        input  ALU_FUN, EN, CLK_EN, WrEn, RdEn, Address, WrData,
        input  BUSY, FRAME_ERR, TIMEOUT_ERR
    );

    modport slave (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT_VALID, RD_DATA_VALID,
        output ALU_FUN, EN, CLK_EN, WrEn, RdEn, Address, WrData,
        output BUSY, FRAME_ERR, TIMEOUT_ERR
    );

endinterface

// File: rtl/sys_ctrl_rx_frame_decoder_vld_edge.sv
// Rising-edge qualifier for the RX byte-valid level.
// The delayed copy resets to 1 so a level held across reset is not a byte.
module sys_ctrl_rx_frame_decoder_vld_edge (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    output logic acc
);
    logic vld_q;

    // Delayed copy of the valid level
    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b1;
        else     vld_q <= vld;
    end

    assign acc = vld & ~vld_q;

endmodule

// File: rtl/sys_ctrl_rx_frame_decoder.sv
// RX frame decoder: turns command byte frames into RF/ALU strobes.
// FSM, inactivity timer and registered output stage.
module sys_ctrl_rx_frame_decoder
    import sys_ctrl_rx_frame_decoder_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int FUN_WIDTH      = FUN_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_WR   = CMD_RF_WR_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_RD   = CMD_RF_RD_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = CMD_ALU_OP_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = CMD_ALU_NOP_DEF,
    parameter int OPA_ADDR       = OPA_ADDR_DEF,
    parameter int OPB_ADDR       = OPB_ADDR_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic                         CLK,
    input logic                         RST,
    sys_ctrl_rx_frame_decoder_if.slave  bus
);
    localparam int TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LIMIT =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic                  byte_acc;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  addr_ok;
    logic                  rsp_done;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_alu_q, rsp_alu_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  en_q, en_d;
    logic                  clk_en_q, clk_en_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  timeout_err_q, timeout_err_d;

    sys_ctrl_rx_frame_decoder_vld_edge u_vld_edge (
        .clk (CLK),
        .rst (RST),
        .vld (bus.RX_D_VLD),
        .acc (byte_acc)
    );

    assign rx_byte  = bus.RX_P_DATA;
    assign addr_ok  = ((rx_byte >> ADDR_WIDTH) == '0);
    assign rsp_done = rsp_alu_q ? bus.ALU_OUT_VALID : bus.RD_DATA_VALID;

    // Next state, next outputs and inactivity timer
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        addr_d        = addr_q;
        rsp_alu_d     = rsp_alu_q;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        en_d          = 1'b0;
        clk_en_d      = clk_en_q;
        alu_fun_d     = alu_fun_q;
        address_d     = '0;
        wr_data_d     = '0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_acc) begin
                    if (rx_byte == CMD_RF_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (rx_byte == CMD_RF_RD) begin
                        state_d = S_RD_ADDR;
                    end else if (rx_byte == CMD_ALU_OP) begin
                        state_d  = S_OPA;
                        clk_en_d = 1'b1;
                    end else if (rx_byte == CMD_ALU_NOP) begin
                        state_d  = S_FUN;
                        clk_en_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR: begin
                if (byte_acc) begin
                    if (addr_ok) begin
                        addr_d  = rx_byte[ADDR_WIDTH-1:0];
                        state_d = S_WR_DATA;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WR_DATA: begin
                if (byte_acc) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = rx_byte;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (byte_acc) begin
                    if (addr_ok) begin
                        rd_en_d   = 1'b1;
                        address_d = rx_byte[ADDR_WIDTH-1:0];
                        rsp_alu_d = 1'b0;
                        state_d   = S_WAIT_RSP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_OPA: begin
                if (byte_acc) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = rx_byte;
                    state_d   = S_OPB;
                end
            end
            S_OPB: begin
                if (byte_acc) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = rx_byte;
                    state_d   = S_FUN;
                end
            end
            S_FUN: begin
                if (byte_acc) begin
                    en_d      = 1'b1;
                    alu_fun_d = rx_byte[FUN_WIDTH-1:0];
                    rsp_alu_d = 1'b1;
                    state_d   = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_done) begin
                    state_d   = S_IDLE;
                    clk_en_d  = 1'b0;
                    alu_fun_d = '0;
                end else if (byte_acc) begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_IDLE || state_d != state_q || byte_acc ||
            TIMEOUT_CYCLES == 0) begin
            timer_d = '0;
        end else if (timer_q == T_LIMIT) begin
            timer_d       = '0;
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
            clk_en_d      = 1'b0;
            alu_fun_d     = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, timer and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            addr_q        <= '0;
            rsp_alu_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            en_q          <= 1'b0;
            clk_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            address_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            addr_q        <= addr_d;
            rsp_alu_q     <= rsp_alu_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            en_q          <= en_d;
            clk_en_q      <= clk_en_d;
            alu_fun_q     <= alu_fun_d;
            address_q     <= address_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.WrEn        = wr_en_q;
    assign bus.RdEn        = rd_en_q;
    assign bus.EN          = en_q;
    assign bus.CLK_EN      = clk_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.Address     = address_q;
    assign bus.WrData      = wr_data_q;
    assign bus.BUSY        = busy_q;
    assign bus.FRAME_ERR   = frame_err_q;
    assign bus.TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_sys_ctrl_rx_frame_decoder.sv
// Bench for the RX frame decoder: directed frames plus random frames
// checked against a transaction-level event model.
module tb_sys_ctrl_rx_frame_decoder;

    localparam int TO    = 16;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_EN  = 3;
    localparam int K_FE  = 4;
    localparam int K_TO  = 5;
    localparam int K_BAD = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  fb[4];
    int          bc[4];

    sys_ctrl_rx_frame_decoder_if #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .FUN_WIDTH  (4)
    ) bus ();

    sys_ctrl_rx_frame_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input int k, input logic [7:0] a,
                                       input logic [7:0] d, input int t);
        logic [31:0] t32;
        logic [7:0]  k8;
        t32 = t;
        k8  = 8'(k);
        return {t32, k8, a, d, 8'h00};
    endfunction

    // Every observed strobe becomes a stamped event
    always @(negedge clk) begin
        if (bus.WrEn)
            obs_q.push_back(mk(K_WR, 8'(bus.Address), bus.WrData, cyc));
        if (bus.RdEn)
            obs_q.push_back(mk(K_RD, 8'(bus.Address), 8'h00, cyc));
        if ((!bus.WrEn && !bus.RdEn && bus.Address != 0) ||
            (!bus.WrEn && bus.WrData != 0))
            obs_q.push_back(mk(K_BAD, 8'(bus.Address), bus.WrData, cyc));
        if (bus.EN)
            obs_q.push_back(mk(K_EN, 8'(bus.ALU_FUN), 8'h00, cyc));
        if (bus.FRAME_ERR)
            obs_q.push_back(mk(K_FE, 8'h00, 8'h00, cyc));
        if (bus.TIMEOUT_ERR)
            obs_q.push_back(mk(K_TO, 8'h00, 8'h00, cyc));
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.WrEn, bus.RdEn, bus.EN, bus.CLK_EN, bus.BUSY,
                    bus.FRAME_ERR, bus.TIMEOUT_ERR, bus.Address,
                    bus.WrData, bus.ALU_FUN});
    endfunction

    task automatic compare_events(input string tag);
        int n;
        check($sformatf("%s_nev", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int lvl, output int t);
        int gap;
        @(negedge clk);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        t = cyc + 1;
        repeat (lvl) @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_DATA = 8'($urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input int lvl);
        int l;
        for (int i = 0; i < n; i++) begin
            l = (lvl > 0) ? lvl : $urandom_range(1, 3);
            send_byte(fb[i], l, bc[i]);
        end
    endtask

    // Expected events of a frame, from the command rules; returns the
    // response awaited: 0 none, 1 RF read, 2 ALU
    task automatic model_frame(input int n, output int wk);
        wk = 0;
        if (fb[0] == 8'hAA) begin
            if (n >= 2 && fb[1] >= 16)
                exp_q.push_back(mk(K_FE, 0, 0, bc[1]));
            else if (n >= 3)
                exp_q.push_back(mk(K_WR, fb[1], fb[2], bc[2]));
        end else if (fb[0] == 8'hBB) begin
            if (n >= 2 && fb[1] >= 16) begin
                exp_q.push_back(mk(K_FE, 0, 0, bc[1]));
            end else if (n >= 2) begin
                exp_q.push_back(mk(K_RD, fb[1], 0, bc[1]));
                wk = 1;
            end
        end else if (fb[0] == 8'hCC) begin
            if (n >= 2) exp_q.push_back(mk(K_WR, 0, fb[1], bc[1]));
            if (n >= 3) exp_q.push_back(mk(K_WR, 1, fb[2], bc[2]));
            if (n >= 4) begin
                exp_q.push_back(mk(K_EN, fb[3] % 16, 0, bc[3]));
                wk = 2;
            end
        end else if (fb[0] == 8'hDD) begin
            if (n >= 2) begin
                exp_q.push_back(mk(K_EN, fb[1] % 16, 0, bc[1]));
                wk = 2;
            end
        end else begin
            exp_q.push_back(mk(K_FE, 0, 0, bc[0]));
        end
    endtask

    task automatic finish_frame(input string tag, input int wk,
                                input logic [3:0] fun, input int dly);
        int d;
        if (wk != 0) begin
            d = (dly > 0) ? dly : $urandom_range(1, 6);
            repeat (d) @(negedge clk);
            check({tag, "_busy_wait"}, 64'(bus.BUSY), 64'd1);
            if (wk == 2) begin
                check({tag, "_clken_wait"}, 64'(bus.CLK_EN), 64'd1);
                check({tag, "_fun_wait"}, 64'(bus.ALU_FUN), 64'(fun));
                bus.ALU_OUT_VALID = 1'b1;
            end else begin
                bus.RD_DATA_VALID = 1'b1;
            end
            @(negedge clk);
            bus.ALU_OUT_VALID = 1'b0;
            bus.RD_DATA_VALID = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_busy_idle"}, 64'(bus.BUSY), 64'd0);
        check({tag, "_clken_idle"}, 64'(bus.CLK_EN), 64'd0);
        check({tag, "_fun_idle"}, 64'(bus.ALU_FUN), 64'd0);
        compare_events(tag);
    endtask

    task automatic run(input string tag, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int n, input int lvl,
                       input int dly);
        int wk;
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
        send_frame(n, lvl);
        model_frame(n, wk);
        finish_frame(tag, wk, (n == 4) ? b3[3:0] : b1[3:0], dly);
    endtask

    initial begin
        int t;
        int wk;
        int typ;
        logic [7:0] r0, r1, r2, r3;

        bus.RX_P_DATA     = 8'hAA;
        bus.RX_D_VLD      = 1'b1;
        bus.ALU_OUT_VALID = 1'b0;
        bus.RD_DATA_VALID = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", outs(), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.RX_D_VLD = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_outs", outs(), 64'd0);
        compare_events("rst_hold");

        run("wr", 8'hAA, 8'h05, 8'h3C, 8'h00, 3, 3, 0);
        run("rd", 8'hBB, 8'h07, 8'h00, 8'h00, 2, 0, 4);
        run("alu", 8'hCC, 8'h12, 8'h34, 8'h01, 4, 0, 0);
        run("badcmd", 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        run("badaddr", 8'hAA, 8'h15, 8'h00, 8'h00, 2, 0, 0);

        fb[0] = 8'hBB; fb[1] = 8'h03;
        send_frame(2, 0);
        model_frame(2, wk);
        send_byte(8'h77, 1, t);
        exp_q.push_back(mk(K_FE, 0, 0, t));
        finish_frame("wait_byte", wk, 4'h0, 2);

        fb[0] = 8'hDD; fb[1] = 8'h02;
        send_frame(2, 0);
        model_frame(2, wk);
        exp_q.push_back(mk(K_TO, 0, 0, bc[1] + TO));
        repeat (TO + 4) @(negedge clk);
        #1;
        check("to_outs", outs(), 64'd0);
        compare_events("timeout");

        fb[0] = 8'hCC; fb[1] = 8'h12;
        send_frame(2, 0);
        model_frame(2, wk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_outs", outs(), 64'd0);
        compare_events("midrst");
        run("after_rst", 8'hAA, 8'h0E, 8'hC3, 8'h00, 3, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) bus.RD_DATA_VALID = 1'b1;
                else                           bus.ALU_OUT_VALID = 1'b1;
                @(negedge clk);
                bus.RD_DATA_VALID = 1'b0;
                bus.ALU_OUT_VALID = 1'b0;
            end
            typ = $urandom_range(0, 5);
            r1 = 8'($urandom_range(0, 15));
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            case (typ)
                0: run("rnd_wr", 8'hAA, r1, r2, r3, 3, 0, 0);
                1: run("rnd_rd", 8'hBB, r1, r2, r3, 2, 0, 0);
                2: run("rnd_alu", 8'hCC, r1, r2, r3, 4, 0, 0);
                3: run("rnd_nop", 8'hDD, r2, r1, r3, 2, 0, 0);
                4: begin
                    r0 = 8'($urandom);
                    while (r0 == 8'hAA || r0 == 8'hBB ||
                           r0 == 8'hCC || r0 == 8'hDD)
                        r0 = 8'($urandom);
                    run("rnd_badcmd", r0, r1, r2, r3, 1, 0, 0);
                end
                default: begin
                    r1 = 8'($urandom_range(16, 255));
                    r0 = ($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB;
                    run("rnd_badaddr", r0, r1, r2, r3, 2, 0, 0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
